// File: rtl/uart_transmitter.sv
// UART transmitter: start, 8 data bits (tx_data[0] first), optional even parity (`TX_PARITY_EN), 1-2 stop bits.
// Latency: start bit appears on TXD the cycle after acceptance; frame = (9 + P + STOP_BITS) * CLKS_PER_BIT cycles.
// Backpressure: one-entry holding register; tx_ready low while it is full, tx_start ignored while tx_ready is low.
module uart_transmitter #(
   parameter int CLKS_PER_BIT = 1,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [0:7] tx_data,
   input  logic       tx_start,
   output logic       tx_ready,
   output logic       TXD,
   output logic       tx_busy
);

   generate
      if (CLKS_PER_BIT < 1 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
         $error("uart_transmitter: CLKS_PER_BIT must be in 1..65535");
      end
      if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
         $error("uart_transmitter: STOP_BITS must be 1 or 2");
      end
   endgenerate

   localparam logic [15:0] LAST_CNT  = 16'(CLKS_PER_BIT - 1);
   localparam logic [2:0]  LAST_STOP = 3'(STOP_BITS - 1);

`ifdef TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t      state;
   logic [15:0] bit_cnt;
   logic [2:0]  bit_idx;
   logic [0:7]  data_reg;
   logic [0:7]  hold_reg;
   logic        hold_full;
   logic        accept;
   logic        bit_done;

   assign tx_ready = ~hold_full;
   assign accept   = tx_start & tx_ready;
   assign bit_done = (bit_cnt == LAST_CNT);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         bit_idx   <= '0;
         data_reg  <= '0;
         hold_reg  <= '0;
         hold_full <= 1'b0;
         TXD       <= 1'b1;
         tx_busy   <= 1'b0;
      end else begin
         if (state != IDLE) begin
            bit_cnt <= bit_done ? '0 : bit_cnt + 16'd1;
            if (accept) begin
               hold_reg  <= tx_data;
               hold_full <= 1'b1;
            end
         end
         case (state)
            IDLE: begin
               if (accept) begin
                  data_reg <= tx_data;
                  bit_cnt  <= '0;
                  state    <= START;
                  TXD      <= 1'b0;
                  tx_busy  <= 1'b1;
               end
            end
            START: begin
               if (bit_done) begin
                  bit_idx <= '0;
                  state   <= DATA;
                  TXD     <= data_reg[0];
               end
            end
            DATA: begin
               if (bit_done) begin
                  if (bit_idx == 3'd7) begin
                     bit_idx <= '0;
`ifdef TX_PARITY_EN
                     state   <= PARITY;
                     TXD     <= ^data_reg;
`else
                     state   <= STOP;
                     TXD     <= 1'b1;
`endif
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     TXD     <= data_reg[bit_idx + 3'd1];
                  end
               end
            end
`ifdef TX_PARITY_EN
            PARITY: begin
               if (bit_done) begin
                  state <= STOP;
                  TXD   <= 1'b1;
               end
            end
`endif
            STOP: begin
               if (bit_done) begin
                  if (bit_idx == LAST_STOP) begin
                     bit_idx <= '0;
                     // Chain the next frame without an idle cycle when a byte is waiting.
                     if (hold_full) begin
                        data_reg  <= hold_reg;
                        hold_full <= 1'b0;
                        state     <= START;
                        TXD       <= 1'b0;
                     end else if (accept) begin
                        data_reg  <= tx_data;
                        hold_full <= 1'b0;
                        state     <= START;
                        TXD       <= 1'b0;
                     end else begin
                        state   <= IDLE;
                        TXD     <= 1'b1;
                        tx_busy <= 1'b0;
                     end
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end
            end
            default: begin
               state   <= IDLE;
               TXD     <= 1'b1;
               tx_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1, clk cycles per serial bit; legal range 1..65535.
REQ-002 SHALL have parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-003 SHALL reject illegal parameter values at elaboration.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port tx_data, input, 8 bits declared [0:7], byte to send; tx_data[0] is transmitted first.
REQ-007 SHALL have port tx_start, input, 1 bit, request to accept tx_data.
REQ-008 SHALL have port tx_ready, output, 1 bit, high when a byte can be accepted.
REQ-009 SHALL have port TXD, output, 1 bit, serial line, registered, idle high.
REQ-010 SHALL have port tx_busy, output, 1 bit, high while a frame is on the line.

Function
REQ-011 SHALL implement states IDLE, START, DATA, PARITY (TX_PARITY_EN builds only) and STOP.
REQ-012 SHALL hold each state for exactly CLKS_PER_BIT cycles per bit, using a bit-time counter and an index over data bits 0..7 and stop bits 1..STOP_BITS.
REQ-013 SHALL drive TXD: IDLE 1; START 0; DATA tx_data[i], i = 0..7 in order; PARITY the parity bit; STOP 1.
REQ-014 SHALL accept a byte on a rising edge where tx_start=1 and tx_ready=1; tx_start with tx_ready=0 is ignored without side effects.
REQ-015 SHALL, on acceptance in IDLE at edge N, enter START and drive TXD=0 in the cycle following edge N.
REQ-016 SHALL, on acceptance while not IDLE, store the byte in a one-entry holding register and deassert tx_ready until that register is emptied.
REQ-017 SHALL, at the end of the final stop bit with the holding register full, go directly to START with no idle cycle, load the held byte, and reassert tx_ready in the same cycle.
REQ-018 SHALL, at the end of the final stop bit with the holding register empty, return to IDLE.
REQ-019 SHALL drive tx_ready = NOT (holding register full); tx_ready is always 1 in IDLE.
REQ-020 SHALL drive tx_busy = 1 in every state except IDLE.
REQ-021 SHALL capture tx_data only at acceptance; later changes to tx_data do not affect a frame already accepted.
REQ-022 SHALL produce frames of length (1 + 8 + P + STOP_BITS) x CLKS_PER_BIT cycles, where P=1 with TX_PARITY_EN and P=0 without.
REQ-023 SHALL keep the line compatible with the team's receiver when CLKS_PER_BIT=1: start bit, then 8 data bits on consecutive cycles, index 0 first.

Reset
REQ-024 SHALL give reset priority over tx_start on the same edge.
REQ-025 SHALL, after a reset edge, set TXD=1, tx_busy=0, tx_ready=1, state IDLE, all counters 0, holding register empty.
REQ-026 SHALL abort a frame in progress on reset mid-frame: TXD=1 from the next cycle, and the in-flight and held bytes are discarded.

Configuration
REQ-027 SHALL use macro TX_PARITY_EN: when defined, insert one even-parity bit (XOR of tx_data[0..7]) between DATA and STOP.
REQ-028 SHALL, when TX_PARITY_EN is undefined, contain no PARITY state or parity logic, and go directly from DATA to STOP.

Verification
REQ-029 SHALL cover the single-frame case: CLKS_PER_BIT=1, STOP_BITS=1, no parity, tx_data[0:7]=1,1,0,0,0,0,0,1, tx_start pulsed at edge N -> TXD over cycles N+1..N+10 = 0,1,1,0,0,0,0,0,1,1; tx_busy high for cycles N+1..N+10, low in cycle N+11.
REQ-030 SHALL cover parity with the same byte under TX_PARITY_EN -> TXD = 0,1,1,0,0,0,0,0,1,1,1; frame length 11 cycles.
REQ-031 SHALL cover back-to-back frames: bytes A and B pulsed at edges N and N+2 -> tx_ready=0 from N+3 until the start of B; B's start bit in cycle N+11; no idle cycle between the frames.
REQ-032 SHALL cover bit timing: CLKS_PER_BIT=4, STOP_BITS=2, byte 8'hFF -> TXD low for 4 cycles then high for 40 cycles; total frame 44 cycles.
REQ-033 SHALL cover reset mid-frame: reset asserted at data bit 3 with a byte held -> TXD=1, tx_busy=0, tx_ready=1 next cycle; no further frame starts.
REQ-034 SHALL cover loopback: TXD tied to the team's receiver RXD, CLKS_PER_BIT=1, 20 random bytes sent back-to-back -> receiver rx_data equals each sent byte.
